// File: rtl/csls_serial_subtractor_if.sv
// Operand/result handshake bundle for csls_serial_subtractor.
// The OVF wire exists only when CSLS_SIGNED_OVF_EN is defined.
interface csls_serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bout;
`ifdef CSLS_SIGNED_OVF_EN
    logic             OVF;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, D, Bout, OVF
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, D, Bout, OVF
    );
`else
    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, D, Bout
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, D, Bout
    );
`endif
endinterface

// File: rtl/csls_serial_subtractor.sv
// Multi-cycle carry-select subtractor: D = A - B, one BLOCK-bit slice per clock from the LSB.
// Optional signed-overflow output is enabled by defining CSLS_SIGNED_OVF_EN.
module csls_serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    csls_serial_subtractor_if.slave  bus
);
    localparam int NSLICE = WIDTH / BLOCK;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

    generate
        if ((WIDTH < BLOCK) || ((WIDTH % BLOCK) != 0)) begin : g_bad_params
            $error("WIDTH must be a non-zero multiple of BLOCK");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_nb;
    logic [WIDTH-1:0] r_d;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_bout;

    logic             w_accept;
    logic             w_release;
    logic             w_last;
    logic [BLOCK-1:0] w_a_slice;
    logic [BLOCK-1:0] w_nb_slice;
    logic [BLOCK:0]   w_sum0;
    logic [BLOCK:0]   w_sum1;
    logic [BLOCK:0]   w_sel;

    // Two's-complement overflow of a - b expressed on sign bits only.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

    assign w_accept  = bus.in_valid & r_in_ready & (r_state == ST_IDLE);
    assign w_release = r_out_valid & bus.out_ready & (r_state == ST_DONE);
    assign w_last    = (r_state == ST_RUN) && (r_cnt == LAST_SLICE);

    assign w_a_slice  = r_a[r_cnt*BLOCK +: BLOCK];
    assign w_nb_slice = r_nb[r_cnt*BLOCK +: BLOCK];

    // Both carry-in outcomes are formed in parallel; the registered carry only drives the mux.
    assign w_sum0 = {1'b0, w_a_slice} + {1'b0, w_nb_slice};
    assign w_sum1 = {1'b0, w_a_slice} + {1'b0, w_nb_slice} + {{BLOCK{1'b0}}, 1'b1};

    // Carry-select mux
    always_comb begin
        w_sel = w_sum0;
        if (r_carry) begin
            w_sel = w_sum1;
        end else begin
            w_sel = w_sum0;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, slice datapath and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a         <= '0;
            r_nb        <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b1;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_bout      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a        <= bus.A;
                        r_nb       <= ~bus.B;
                        r_d        <= '0;
                        r_carry    <= 1'b1;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_d[r_cnt*BLOCK +: BLOCK] <= w_sel[BLOCK-1:0];
                    r_carry                   <= w_sel[BLOCK];
                    if (w_last) begin
                        r_bout      <= ~w_sel[BLOCK];
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (w_release) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef CSLS_SIGNED_OVF_EN
    logic r_ovf;

    // Overflow flag is captured on the last slice, when the result sign bit is produced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= signed_ovf(r_a[WIDTH-1], ~r_nb[WIDTH-1], w_sel[BLOCK-1]);
        end
    end

    assign bus.OVF = r_ovf;
`endif

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.D         = r_d;
    assign bus.Bout      = r_bout;

endmodule
